// File: rtl/bullet_pkg.sv
// Shared definitions for the bullet hit scanner: colour codes, packed
// position/size field layout and the scan FSM state type.
package bullet_pkg;

  // One coordinate or extent field; sums of two fields need one extra bit.
  localparam int unsigned FIELD_W = 8;
  localparam int unsigned SUM_W   = FIELD_W + 1;
  localparam int unsigned VEC_W   = 2 * FIELD_W;

  // {x, y} and {width, height} packing inside a 16-bit vector.
  localparam int unsigned X_MSB = 15;
  localparam int unsigned X_LSB = 8;
  localparam int unsigned Y_MSB = 7;
  localparam int unsigned Y_LSB = 0;

  localparam logic [2:0] COLOR_WHITE = 3'b000;
  localparam logic [2:0] COLOR_GREEN = 3'b001;
  localparam logic [2:0] COLOR_BLUE  = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StHit,
    StDone
  } scan_state_e;

  function automatic logic [FIELD_W-1:0] field_x(input logic [VEC_W-1:0] v);
    return v[X_MSB:X_LSB];
  endfunction

  function automatic logic [FIELD_W-1:0] field_y(input logic [VEC_W-1:0] v);
    return v[Y_MSB:Y_LSB];
  endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box overlap test. Box ends are computed at
// 9 bits so boxes near the 255 edge never wrap around to 0. A box with zero
// width or height never overlaps anything.
module aabb_overlap
  import bullet_pkg::*;
(
  input  logic [FIELD_W-1:0] a_x,
  input  logic [FIELD_W-1:0] a_y,
  input  logic [FIELD_W-1:0] a_w,
  input  logic [FIELD_W-1:0] a_h,
  input  logic [FIELD_W-1:0] b_x,
  input  logic [FIELD_W-1:0] b_y,
  input  logic [FIELD_W-1:0] b_w,
  input  logic [FIELD_W-1:0] b_h,
  output logic               overlap
);

  logic [SUM_W-1:0] a_x_end, a_y_end, b_x_end, b_y_end;
  logic             non_empty;

  // Strict-inequality interval overlap on both axes.
  always_comb begin
    a_x_end   = {1'b0, a_x} + {1'b0, a_w};
    a_y_end   = {1'b0, a_y} + {1'b0, a_h};
    b_x_end   = {1'b0, b_x} + {1'b0, b_w};
    b_y_end   = {1'b0, b_y} + {1'b0, b_h};
    non_empty = (a_w != '0) && (a_h != '0) && (b_w != '0) && (b_h != '0);
    overlap   = non_empty
              && ({1'b0, b_x} < a_x_end) && ({1'b0, a_x} < b_x_end)
              && ({1'b0, b_y} < a_y_end) && ({1'b0, a_y} < b_y_end);
  end

endmodule

// File: rtl/bullet_hit_scanner.sv
// Per-frame bullet collision scanner. Walks every bullet slot through the
// bullet table's second read port, pulses is_collide with the slot index on
// each hit and maintains player HP and the sticky dead flag.
// Optional feature macro: HIT_INVULN_EN (post-damage invulnerability frames).
module bullet_hit_scanner
  import bullet_pkg::*;
#(
  parameter int unsigned N_BULLETS     = 8,
  parameter int unsigned IDX_W         = 3,
  parameter int unsigned HP_MAX        = 20,
  parameter int unsigned DMG           = 1,
  parameter int unsigned INVULN_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      player_pos,
  input  logic [15:0]      player_size,
  input  logic             player_moving,
  output logic [IDX_W-1:0] bullet_index,
  input  logic [15:0]      bullet_pos,
  input  logic [15:0]      bullet_size,
  input  logic [2:0]       bullet_color,
  input  logic             bullet_render,
  output logic             is_collide,
  output logic [7:0]       hp,
  output logic             dead,
  output logic             busy,
  output logic             done
);

`ifdef HIT_INVULN_EN
  localparam bit InvulnEn = 1'b1;
`else
  localparam bit InvulnEn = 1'b0;
`endif

  localparam logic [7:0] DmgW    = 8'(DMG);
  localparam logic [8:0] HpMaxW  = 9'(HP_MAX);
  localparam logic [7:0] HpReset = 8'(HP_MAX);

  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [2:0]       color_q, color_d;
  logic             moving_q, moving_d;
  logic [7:0]       hp_q, hp_d;
  logic             dead_q, dead_d;
  logic             overlap, slot_hit, last_slot;
  logic             is_damaging, is_heal, blocked, dmg_apply;
  logic [8:0]       hp_heal;

  aabb_overlap u_overlap (
    .a_x     (field_x(player_pos)),
    .a_y     (field_y(player_pos)),
    .a_w     (field_x(player_size)),
    .a_h     (field_y(player_size)),
    .b_x     (field_x(bullet_pos)),
    .b_y     (field_y(bullet_pos)),
    .b_w     (field_x(bullet_size)),
    .b_h     (field_y(bullet_size)),
    .overlap (overlap)
  );

  assign slot_hit  = bullet_render && overlap;
  assign last_slot = (idx_q == IDX_W'(N_BULLETS - 1));

  // Scan FSM: one cycle per slot, an extra HIT cycle per colliding slot.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    color_d  = color_q;
    moving_d = moving_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StScan;
          idx_d   = '0;
        end
      end
      StScan: begin
        if (slot_hit) begin
          // Freeze the hit attributes; the HP effect is applied leaving HIT.
          state_d  = StHit;
          color_d  = bullet_color;
          moving_d = player_moving;
        end else if (last_slot) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StHit: begin
        if (last_slot) begin
          state_d = StDone;
        end else begin
          state_d = StScan;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  // HP effect of the hit being reported this cycle.
  always_comb begin
    hp_d        = hp_q;
    dead_d      = dead_q;
    dmg_apply   = 1'b0;
    is_damaging = (color_q == COLOR_WHITE) || ((color_q == COLOR_BLUE) && moving_q);
    is_heal     = (color_q == COLOR_GREEN);
    hp_heal     = {1'b0, hp_q} + {1'b0, DmgW};
    if (state_q == StHit) begin
      if (is_damaging) begin
        if (!blocked) begin
          dmg_apply = 1'b1;
          hp_d      = (hp_q > DmgW) ? hp_q - DmgW : '0;
          if (hp_d == '0) begin
            dead_d = 1'b1;
          end
        end
      end else if (is_heal && !dead_q) begin
        hp_d = (hp_heal > HpMaxW) ? HpReset : hp_heal[7:0];
      end
    end
  end

  // State, slot index, latched hit attributes and HP registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      color_q  <= COLOR_WHITE;
      moving_q <= 1'b0;
      hp_q     <= HpReset;
      dead_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      color_q  <= color_d;
      moving_q <= moving_d;
      hp_q     <= hp_d;
      dead_q   <= dead_d;
    end
  end

  if (InvulnEn) begin : g_invuln
    logic [7:0] inv_q, inv_d;

    // Frame counter: reloads on applied damage, counts down once per scan.
    always_comb begin
      inv_d = inv_q;
      if (dmg_apply) begin
        inv_d = 8'(INVULN_FRAMES);
      end else if (done && (inv_q != '0)) begin
        inv_d = inv_q - 8'd1;
      end
    end

    // Invulnerability counter register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        inv_q <= '0;
      end else begin
        inv_q <= inv_d;
      end
    end

    assign blocked = (inv_q != '0);
  end else begin : g_no_invuln
    assign blocked = 1'b0;
  end

  assign bullet_index = idx_q;
  assign is_collide   = (state_q == StHit);
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign hp           = hp_q;
  assign dead         = dead_q;

endmodule

// File: tb/tb_bullet_hit_scanner.sv
// Self-checking bench for bullet_hit_scanner: a table of single-slot frames,
// hand-written multi-frame sequences (death, reset mid-scan, ignored start)
// and randomized frames checked against a behavioural model.
module tb_bullet_hit_scanner;

  localparam int NB     = 8;
  localparam int HP_MAX = 20;
  localparam int DMG    = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] player_pos, player_size;
  logic        player_moving;
  logic [2:0]  bullet_index;
  logic [15:0] bullet_pos, bullet_size;
  logic [2:0]  bullet_color;
  logic        bullet_render;
  logic        is_collide;
  logic [7:0]  hp;
  logic        dead, busy, done;

  // Bullet table contents, read combinationally by bullet_index.
  logic [7:0] tx [NB];
  logic [7:0] ty [NB];
  logic [7:0] tw [NB];
  logic [7:0] th [NB];
  logic [2:0] tc [NB];
  logic       tr [NB];

  assign bullet_pos    = {tx[bullet_index], ty[bullet_index]};
  assign bullet_size   = {tw[bullet_index], th[bullet_index]};
  assign bullet_color  = tc[bullet_index];
  assign bullet_render = tr[bullet_index];

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int m_hp;
  bit m_dead;
  int m_inv;
  int exp_q[$];

  bullet_hit_scanner dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .player_pos    (player_pos),
    .player_size   (player_size),
    .player_moving (player_moving),
    .bullet_index  (bullet_index),
    .bullet_pos    (bullet_pos),
    .bullet_size   (bullet_size),
    .bullet_color  (bullet_color),
    .bullet_render (bullet_render),
    .is_collide    (is_collide),
    .hp            (hp),
    .dead          (dead),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < NB; i++) begin
      tx[i] = 8'd0; ty[i] = 8'd0; tw[i] = 8'd0; th[i] = 8'd0; tc[i] = 3'd0; tr[i] = 1'b0;
    end
  endtask

  task automatic set_slot(input int s, input int x, input int y, input int w, input int h,
                          input int c, input bit r);
    tx[s] = 8'(x); ty[s] = 8'(y); tw[s] = 8'(w); th[s] = 8'(h); tc[s] = 3'(c); tr[s] = r;
  endtask

  task automatic set_player(input int x, input int y, input int w, input int h);
    player_pos  = {8'(x), 8'(y)};
    player_size = {8'(w), 8'(h)};
  endtask

  task automatic model_reset();
    m_hp   = HP_MAX;
    m_dead = 1'b0;
    m_inv  = 0;
  endtask

  task automatic apply_reset();
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Plain-integer box overlap straight from the hit rule.
  function automatic bit model_overlap(input int s);
    int px, py, pw, ph, bx, by, bw, bh;
    px = int'(player_pos[15:8]);  py = int'(player_pos[7:0]);
    pw = int'(player_size[15:8]); ph = int'(player_size[7:0]);
    bx = int'(tx[s]); by = int'(ty[s]); bw = int'(tw[s]); bh = int'(th[s]);
    if (!tr[s] || pw == 0 || ph == 0 || bw == 0 || bh == 0) return 1'b0;
    return (bx < px + pw) && (px < bx + bw) && (by < py + ph) && (py < by + bh);
  endfunction

  task automatic model_effect(input int col, input bit mv);
    if (col == 0 || (col == 2 && mv)) begin
      if (m_inv == 0) begin
        m_hp = (m_hp > DMG) ? m_hp - DMG : 0;
        if (m_hp == 0) m_dead = 1'b1;
`ifdef HIT_INVULN_EN
        m_inv = 4;
`endif
      end
    end else if (col == 1 && !m_dead) begin
      m_hp = (m_hp + DMG > HP_MAX) ? HP_MAX : m_hp + DMG;
    end
  endtask

  // Predict the hit list and end-of-frame HP for the current table.
  task automatic model_frame();
    exp_q.delete();
    for (int s = 0; s < NB; s++) begin
      if (model_overlap(s)) begin
        exp_q.push_back(s);
        model_effect(int'(tc[s]), player_moving);
      end
    end
    if (m_inv > 0) m_inv--;
  endtask

  // Pulse start, watch the whole scan and compare against exp_q / HP.
  task automatic run_frame(input string name, input int exp_hp, input bit exp_dead,
                           input bit restart_mid);
    int got_q[$];
    int done_at = 0;
    int not_busy = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      if (restart_mid && t == 3) start = 1'b1;
      if (restart_mid && t == 4) start = 1'b0;
      if (is_collide) got_q.push_back(int'(bullet_index));
      if (!busy) not_busy++;
      if (done) begin
        done_at = t;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({name, " done cycle"}, done_at, NB + exp_q.size() + 1);
    check({name, " busy gaps"}, not_busy, 0);
    check({name, " hit count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({name, " hit index"}, got_q[i], exp_q[i]);
    end
    check({name, " hp"}, hp, exp_hp);
    check({name, " dead"}, dead, exp_dead);
    @(negedge clk);
    check({name, " busy after"}, busy, 0);
    check({name, " done pulse width"}, done, 0);
    if (restart_mid) begin
      repeat (3) @(negedge clk);
      check({name, " start not queued"}, busy, 0);
    end
  endtask

  typedef struct {
    string name;
    int    px, py, pw, ph;
    int    slot;
    int    bx, by, bw, bh;
    int    col;
    bit    ren;
    bit    mv;
    bit    exp_hit;
    int    exp_hp;
  } vec_t;

  vec_t tbl[14];

  task automatic table_test();
    tbl[0]  = '{"render off",   50, 50, 16, 16, 3,  60,  60,  8,  8, 0, 0, 0, 0, 20};
    tbl[1]  = '{"white hit",    50, 50, 16, 16, 3,  60,  60,  8,  8, 0, 1, 0, 1, 19};
    tbl[2]  = '{"blue still",   50, 50, 16, 16, 0,  55,  55,  4,  4, 2, 1, 0, 1, 19};
    tbl[3]  = '{"blue moving",  50, 50, 16, 16, 0,  55,  55,  4,  4, 2, 1, 1, 1, 18};
    tbl[4]  = '{"green 18",     50, 50, 16, 16, 1,  45,  45, 10, 10, 1, 1, 0, 1, 19};
    tbl[5]  = '{"green 19",     50, 50, 16, 16, 1,  45,  45, 10, 10, 1, 1, 1, 1, 20};
    tbl[6]  = '{"green cap",    50, 50, 16, 16, 1,  45,  45, 10, 10, 1, 1, 0, 1, 20};
    tbl[7]  = '{"x edge miss",  50, 50, 16, 16, 2,  66,  55,  8,  8, 0, 1, 0, 0, 20};
    tbl[8]  = '{"x edge hit",   50, 50, 16, 16, 2,  65,  55,  8,  8, 0, 1, 0, 1, 19};
    tbl[9]  = '{"odd colour",   50, 50, 16, 16, 4,  52,  52,  4,  4, 7, 1, 1, 1, 19};
    tbl[10] = '{"zero width",   50, 50, 16, 16, 5,  55,  55,  0,  8, 0, 1, 0, 0, 19};
    tbl[11] = '{"no wrap",       0,  0,  8,  8, 6, 250,   0, 10, 10, 0, 1, 0, 0, 19};
    tbl[12] = '{"high corner", 200,200, 60, 60, 7, 250, 250, 10, 10, 0, 1, 0, 1, 18};
    tbl[13] = '{"y edge miss",  50, 50, 16, 16, 2,  55,  40,  8, 10, 0, 1, 0, 0, 18};
    for (int v = 0; v < 14; v++) begin
      clear_slots();
      set_player(tbl[v].px, tbl[v].py, tbl[v].pw, tbl[v].ph);
      set_slot(tbl[v].slot, tbl[v].bx, tbl[v].by, tbl[v].bw, tbl[v].bh, tbl[v].col, tbl[v].ren);
      player_moving = tbl[v].mv;
      exp_q.delete();
      if (tbl[v].exp_hit) exp_q.push_back(tbl[v].slot);
      run_frame(tbl[v].name, tbl[v].exp_hp, 1'b0, 1'b0);
    end
  endtask

  task automatic death_test();
    apply_reset();
    set_player(50, 50, 16, 16);
    player_moving = 1'b0;
    clear_slots();
    exp_q.delete();
    for (int s = 0; s < NB; s++) begin
      set_slot(s, 52 + s, 52, 4, 4, 0, 1'b1);
      exp_q.push_back(s);
    end
    run_frame("eight whites", 12, 1'b0, 1'b0);
    tr[7] = 1'b0;
    void'(exp_q.pop_back());
    run_frame("seven whites", 5, 1'b0, 1'b0);
    clear_slots();
    set_slot(1, 55, 55, 4, 4, 1, 1'b1);
    exp_q = '{1};
    run_frame("green at 5", 6, 1'b0, 1'b0);
    clear_slots();
    exp_q.delete();
    for (int s = 0; s < 5; s++) begin
      set_slot(s, 55, 55, 4, 4, 0, 1'b1);
      exp_q.push_back(s);
    end
    run_frame("five whites", 1, 1'b0, 1'b0);
    clear_slots();
    set_slot(0, 55, 55, 4, 4, 0, 1'b1);
    exp_q = '{0};
    run_frame("fatal white", 0, 1'b1, 1'b0);
    set_slot(1, 55, 55, 4, 4, 1, 1'b1);
    set_slot(2, 55, 55, 4, 4, 0, 1'b1);
    exp_q = '{0, 1, 2};
    run_frame("after death", 0, 1'b1, 1'b1);
  endtask

  task automatic reset_mid_scan_test();
    apply_reset();
    set_player(50, 50, 16, 16);
    clear_slots();
    set_slot(0, 55, 55, 4, 4, 0, 1'b1);
    set_slot(1, 55, 55, 4, 4, 0, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Cycles: 1 scan0, 2 hit0, 3 scan1, 4 hit1.
    repeat (3) @(negedge clk);
    check("mid hit pulse", is_collide, 1);
    check("mid hit index", bullet_index, 1);
    check("mid hp", hp, 19);
    rst_n = 1'b0;
    #1;
    check("rst index", bullet_index, 0);
    check("rst collide", is_collide, 0);
    check("rst hp", hp, HP_MAX);
    check("rst dead", dead, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    clear_slots();
    exp_q.delete();
    run_frame("after reset", HP_MAX, 1'b0, 1'b0);
  endtask

  task automatic random_test();
    apply_reset();
    for (int f = 0; f < 48; f++) begin
      int px, py, pw, ph;
      if (f % 12 == 11) apply_reset();
      px = $urandom_range(0, 255);
      py = $urandom_range(0, 255);
      pw = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      ph = $urandom_range(1, 40);
      set_player(px, py, pw, ph);
      player_moving = 1'($urandom_range(0, 1));
      for (int s = 0; s < NB; s++) begin
        int bx, by, col;
        if ($urandom_range(0, 1) == 1) begin
          bx = (px + $urandom_range(0, 60) - 20) & 255;
          by = (py + $urandom_range(0, 60) - 20) & 255;
        end else begin
          bx = $urandom_range(0, 255);
          by = $urandom_range(0, 255);
        end
        col = $urandom_range(0, 4);
        if (col == 4) col = $urandom_range(3, 7);
        set_slot(s, bx, by, $urandom_range(0, 24), $urandom_range(1, 24), col,
                 $urandom_range(0, 3) != 0);
      end
      model_frame();
      run_frame("random", m_hp, m_dead, 1'b0);
    end
  endtask

`ifdef HIT_INVULN_EN
  task automatic invuln_test();
    apply_reset();
    set_player(50, 50, 16, 16);
    clear_slots();
    set_slot(0, 55, 55, 4, 4, 0, 1'b1);
    exp_q = '{0};
    run_frame("invuln first", 19, 1'b0, 1'b0);
    run_frame("invuln second", 19, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    player_moving = 1'b0;
    set_player(50, 50, 16, 16);
    clear_slots();
    model_reset();
    #12;
    check("reset index", bullet_index, 0);
    check("reset collide", is_collide, 0);
    check("reset hp", hp, HP_MAX);
    check("reset dead", dead, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef HIT_INVULN_EN
    invuln_test();
`else
    table_test();
    death_test();
`endif
    reset_mid_scan_test();
    random_test();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
